// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types and constants for the FPU special-case resolver
package fpu_pkg;

   typedef enum logic [2:0] {
      FPU_ADD = 3'd0,
      FPU_SUB = 3'd1,
      FPU_MUL = 3'd2,
      FPU_DIV = 3'd3
   } fpu_op_e;

   localparam logic [31:0] QNAN  = 32'h7FC0_0000;
   localparam logic [31:0] P_INF = 32'h7F80_0000;
   localparam logic [31:0] N_INF = 32'hFF80_0000;

   // Special-number flags as produced by the upstream detector
   typedef struct packed {
      logic inf;
      logic ind;
      logic qnan;
      logic snan;
      logic opa_inf;
      logic opb_inf;
      logic opa_00;
      logic opb_00;
   } exc_flags_t;

   // One resolved decision, before it is registered
   typedef struct packed {
      logic        hit;
      logic [31:0] result;
      logic        invalid;
      logic        div_zero;
   } exc_res_t;

   function automatic logic [31:0] signed_inf(input logic s);
      return s ? N_INF : P_INF;
   endfunction

endpackage

// File: rtl/fpu_exc_sticky.sv
// rtl/fpu_exc_sticky.sv - sticky exception bits and saturating invalid-op counter
module fpu_exc_sticky #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_sticky,
   input  logic             set_inv,
   input  logic             set_dz,
   output logic             sticky_inv,
   output logic             sticky_dz,
   output logic [CNT_W-1:0] inv_cnt
);

   // A new flag beats a coincident clear; the counter restarts at 1 in that case
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sticky_inv <= 1'b0;
         sticky_dz  <= 1'b0;
         inv_cnt    <= '0;
      end else begin
         if (set_inv)
            sticky_inv <= 1'b1;
         else if (clr_sticky)
            sticky_inv <= 1'b0;

         if (set_dz)
            sticky_dz <= 1'b1;
         else if (clr_sticky)
            sticky_dz <= 1'b0;

         if (clr_sticky)
            inv_cnt <= set_inv ? CNT_W'(1) : '0;
         else if (set_inv && (inv_cnt != '1))
            inv_cnt <= inv_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fpu_exc_resolve.sv
// rtl/fpu_exc_resolve.sv - resolves special-case results and exception flags per FPU op
module fpu_exc_resolve
   import fpu_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [2:0]       fpu_op,
   input  logic             sign_a,
   input  logic             sign_b,
   input  logic             qnan,
   input  logic             snan,
   input  logic             inf,
   input  logic             ind,
   input  logic             opa_inf,
   input  logic             opb_inf,
   input  logic             opa_00,
   input  logic             opb_00,
   input  logic             clr_sticky,
   output logic             out_valid,
   output logic             spec_hit,
   output logic [31:0]      spec_result,
   output logic             invalid,
   output logic             div_zero,
   output logic             sticky_inv,
   output logic             sticky_dz,
   output logic [CNT_W-1:0] inv_cnt
);

   logic [LAT-1:0] v_pipe;
   logic [2:0]     op_pipe [LAT];
   logic [LAT-1:0] sa_pipe;
   logic [LAT-1:0] sb_pipe;

   logic           v_al;
   logic [2:0]     op_al;
   logic           sa_al;
   logic           sb_al;
   logic           eff_sb;
   logic           sxor;
   exc_flags_t     flags;
   exc_res_t       dec;

   assign flags = {inf, ind, qnan, snan, opa_inf, opb_inf, opa_00, opb_00};

   // Delay op control so it lines up with the detector flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_pipe  <= '0;
         sa_pipe <= '0;
         sb_pipe <= '0;
         for (int i = 0; i < LAT; i++)
            op_pipe[i] <= '0;
      end else begin
         v_pipe[0]  <= valid_in;
         op_pipe[0] <= fpu_op;
         sa_pipe[0] <= sign_a;
         sb_pipe[0] <= sign_b;
         for (int i = 1; i < LAT; i++) begin
            v_pipe[i]  <= v_pipe[i-1];
            op_pipe[i] <= op_pipe[i-1];
            sa_pipe[i] <= sa_pipe[i-1];
            sb_pipe[i] <= sb_pipe[i-1];
         end
      end
   end

   assign v_al   = v_pipe[LAT-1];
   assign op_al  = op_pipe[LAT-1];
   assign sa_al  = sa_pipe[LAT-1];
   assign sb_al  = sb_pipe[LAT-1];
   assign eff_sb = (op_al == FPU_SUB) ? ~sb_al : sb_al;
   assign sxor   = sa_al ^ sb_al;

   // Priority decision; reserved opcodes and idle cycles never override the datapath
   always_comb begin
      dec = '0;
      if (v_al && !op_al[2]) begin
         if (flags.snan) begin
            dec.hit     = 1'b1;
            dec.result  = QNAN;
            dec.invalid = 1'b1;
         end else if (flags.qnan) begin
            dec.hit    = 1'b1;
            dec.result = QNAN;
         end else begin
            case (op_al)
               FPU_ADD, FPU_SUB: begin
                  if (flags.ind && (sa_al != eff_sb)) begin
                     dec.hit     = 1'b1;
                     dec.result  = QNAN;
                     dec.invalid = 1'b1;
                  end else if (flags.inf) begin
                     dec.hit    = 1'b1;
                     dec.result = signed_inf(flags.opa_inf ? sa_al : eff_sb);
                  end
               end
               FPU_MUL: begin
                  if ((flags.opa_inf && flags.opb_00) || (flags.opb_inf && flags.opa_00)) begin
                     dec.hit     = 1'b1;
                     dec.result  = QNAN;
                     dec.invalid = 1'b1;
                  end else if (flags.inf) begin
                     dec.hit    = 1'b1;
                     dec.result = signed_inf(sxor);
                  end
               end
               FPU_DIV: begin
                  if (flags.ind || (flags.opa_00 && flags.opb_00)) begin
                     dec.hit     = 1'b1;
                     dec.result  = QNAN;
                     dec.invalid = 1'b1;
                  end else if (flags.opa_inf) begin
                     dec.hit    = 1'b1;
                     dec.result = signed_inf(sxor);
                  end else if (flags.opb_inf) begin
                     dec.hit    = 1'b1;
                     dec.result = {sxor, 31'b0};
                  end else if (flags.opb_00) begin
                     dec.hit      = 1'b1;
                     dec.result   = signed_inf(sxor);
                     dec.div_zero = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Register the decision; flags are already zero when the slot is empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid   <= 1'b0;
         spec_hit    <= 1'b0;
         spec_result <= '0;
         invalid     <= 1'b0;
         div_zero    <= 1'b0;
      end else begin
         out_valid   <= v_al;
         spec_hit    <= dec.hit;
         spec_result <= dec.result;
         invalid     <= dec.invalid;
         div_zero    <= dec.div_zero;
      end
   end

   fpu_exc_sticky #(
      .CNT_W (CNT_W)
   ) u_sticky (
      .clk        (clk),
      .reset      (reset),
      .clr_sticky (clr_sticky),
      .set_inv    (dec.invalid),
      .set_dz     (dec.div_zero),
      .sticky_inv (sticky_inv),
      .sticky_dz  (sticky_dz),
      .inv_cnt    (inv_cnt)
   );

endmodule

// File: tb/tb_fpu_exc_resolve.sv
// tb/tb_fpu_exc_resolve.sv - scoreboard bench for fpu_exc_resolve
module tb_fpu_exc_resolve;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [2:0]  fpu_op;
   logic        sign_a;
   logic        sign_b;
   logic        clr_sticky;
   logic [31:0] cur_opa;
   logic [31:0] cur_opb;
   exc_flags_t  fl1, fl2;

   logic        out_valid, spec_hit, invalid, div_zero, sticky_inv, sticky_dz;
   logic [31:0] spec_result;
   logic [15:0] inv_cnt;
   logic        out_valid4, spec_hit4, invalid4, div_zero4, sticky_inv4, sticky_dz4;
   logic [31:0] spec_result4;
   logic [3:0]  inv_cnt4;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic        hit;
      logic [31:0] res;
      logic        inv;
      logic        dz;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   fpu_exc_resolve #(.CNT_W(16), .LAT(2)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .fpu_op(fpu_op),
      .sign_a(sign_a), .sign_b(sign_b),
      .qnan(fl2.qnan), .snan(fl2.snan), .inf(fl2.inf), .ind(fl2.ind),
      .opa_inf(fl2.opa_inf), .opb_inf(fl2.opb_inf), .opa_00(fl2.opa_00), .opb_00(fl2.opb_00),
      .clr_sticky(clr_sticky), .out_valid(out_valid), .spec_hit(spec_hit),
      .spec_result(spec_result), .invalid(invalid), .div_zero(div_zero),
      .sticky_inv(sticky_inv), .sticky_dz(sticky_dz), .inv_cnt(inv_cnt)
   );

   fpu_exc_resolve #(.CNT_W(4), .LAT(2)) dut4 (
      .clk(clk), .reset(reset), .valid_in(valid_in), .fpu_op(fpu_op),
      .sign_a(sign_a), .sign_b(sign_b),
      .qnan(fl2.qnan), .snan(fl2.snan), .inf(fl2.inf), .ind(fl2.ind),
      .opa_inf(fl2.opa_inf), .opb_inf(fl2.opb_inf), .opa_00(fl2.opa_00), .opb_00(fl2.opb_00),
      .clr_sticky(clr_sticky), .out_valid(out_valid4), .spec_hit(spec_hit4),
      .spec_result(spec_result4), .invalid(invalid4), .div_zero(div_zero4),
      .sticky_inv(sticky_inv4), .sticky_dz(sticky_dz4), .inv_cnt(inv_cnt4)
   );

   // Stand-in for the upstream detector: classify operands, deliver flags two cycles later
   function automatic exc_flags_t detect(input logic [31:0] a, input logic [31:0] b);
      exc_flags_t f;
      logic a_ff, b_ff, a_m0, b_m0;
      a_ff = (a[30:23] == 8'hFF);
      b_ff = (b[30:23] == 8'hFF);
      a_m0 = (a[22:0] == 23'h0);
      b_m0 = (b[22:0] == 23'h0);
      f.opa_inf = a_ff & a_m0;
      f.opb_inf = b_ff & b_m0;
      f.snan    = (a_ff & !a_m0 & !a[22]) | (b_ff & !b_m0 & !b[22]);
      f.qnan    = (a_ff & !a_m0 & a[22]) | (b_ff & !b_m0 & b[22]);
      f.inf     = f.opa_inf | f.opb_inf;
      f.ind     = f.opa_inf & f.opb_inf;
      f.opa_00  = (a[30:0] == 31'h0);
      f.opb_00  = (b[30:0] == 31'h0);
      return f;
   endfunction

   always @(posedge clk) begin
      fl1 <= valid_in ? detect(cur_opa, cur_opb) : '0;
      fl2 <= fl1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every presented result is matched against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0) begin
         if (out_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out_valid actual=1 required=0 at cyc %0d", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("spec_hit", spec_hit, e.hit);
               chk("spec_result", spec_result, e.res);
               chk("invalid", invalid, e.inv);
               chk("div_zero", div_zero, e.dz);
               chk("latency_cyc", cyc, e.cyc);
            end
         end else begin
            chk("idle_outputs_zero", {spec_hit, invalid, div_zero, spec_result}, 64'h0);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic h, input logic [31:0] r, input logic i, input logic d);
      exp_t e;
      @(negedge clk);
      valid_in = 1'b1;
      fpu_op   = op;
      sign_a   = a[31];
      sign_b   = b[31];
      cur_opa  = a;
      cur_opb  = b;
      e.hit = h; e.res = r; e.inv = i; e.dz = d; e.cyc = cyc + 3;
      sb_q.push_back(e);
   endtask

   task automatic idle1();
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int ov_seen;
      reset = 1'b1; valid_in = 1'b0; fpu_op = 3'd0; sign_a = 1'b0; sign_b = 1'b0;
      clr_sticky = 1'b0; cur_opa = '0; cur_opb = '0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_spec", {spec_hit, invalid, div_zero, spec_result}, 0);
      chk("rst_sticky", {sticky_inv, sticky_dz}, 0);
      chk("rst_inv_cnt", inv_cnt, 0);
      reset = 1'b0;

      // +inf + -inf
      issue(3'd0, 32'h7F800000, 32'hFF800000, 1, 32'h7FC00000, 1, 0);
      idle1();
      drain();
      chk("sticky_inv_after_inf_sub", sticky_inv, 1);
      chk("inv_cnt_one", inv_cnt, 1);
      chk("sticky_dz_clear", sticky_dz, 0);

      @(negedge clk); clr_sticky = 1'b1;
      @(negedge clk); clr_sticky = 1'b0;
      chk("clr_sticky_inv", sticky_inv, 0);
      chk("clr_inv_cnt", inv_cnt, 0);

      // divide by zero, both signs
      issue(3'd3, 32'h3F800000, 32'h00000000, 1, 32'h7F800000, 0, 1);
      issue(3'd3, 32'hBF800000, 32'h00000000, 1, 32'hFF800000, 0, 1);
      idle1();
      drain();
      chk("sticky_dz_set", sticky_dz, 1);
      chk("sticky_inv_still_0", sticky_inv, 0);

      // mul cases, then 8 mixed back-to-back, then extras
      issue(3'd2, 32'h7F800000, 32'h80000000, 1, 32'h7FC00000, 1, 0);
      issue(3'd2, 32'h7F800000, 32'hC0000000, 1, 32'hFF800000, 0, 0);
      issue(3'd0, 32'h7F800001, 32'h3F800000, 1, 32'h7FC00000, 1, 0);
      issue(3'd1, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 1, 0);
      issue(3'd1, 32'h7F800000, 32'hFF800000, 1, 32'h7F800000, 0, 0);
      issue(3'd0, 32'h3F800000, 32'hFF800000, 1, 32'hFF800000, 0, 0);
      issue(3'd3, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 1, 0);
      issue(3'd3, 32'h3F800000, 32'hFF800000, 1, 32'h80000000, 0, 0);
      issue(3'd0, 32'h3F800000, 32'h40000000, 0, 32'h00000000, 0, 0);
      issue(3'd2, 32'h7FC00000, 32'h3F800000, 1, 32'h7FC00000, 0, 0);
      issue(3'd5, 32'h7F800000, 32'hFF800000, 0, 32'h00000000, 0, 0);
      issue(3'd3, 32'h00000000, 32'h80000000, 1, 32'h7FC00000, 1, 0);
      issue(3'd3, 32'hFF800000, 32'h3F800000, 1, 32'hFF800000, 0, 0);
      idle1();
      drain();
      chk("inv_cnt_after_mixed", inv_cnt, 5);
      chk("inv_cnt4_after_mixed", inv_cnt4, 5);

      // clear coincident with a new invalid result
      issue(3'd0, 32'h7F800001, 32'h00000000, 1, 32'h7FC00000, 1, 0);
      idle1();
      @(negedge clk); clr_sticky = 1'b1;
      @(negedge clk); clr_sticky = 1'b0;
      chk("coincident_sticky_inv", sticky_inv, 1);
      chk("coincident_inv_cnt", inv_cnt, 1);
      chk("coincident_sticky_dz", sticky_dz, 0);
      drain();

      // saturation of the 4-bit counter
      for (int k = 0; k < 17; k++)
         issue(3'd2, 32'h3F800000, 32'hFF800001, 1, 32'h7FC00000, 1, 0);
      idle1();
      drain();
      chk("inv_cnt4_saturated", inv_cnt4, 15);
      chk("inv_cnt16_no_sat", inv_cnt, 18);

      // reset with three ops in flight
      issue(3'd0, 32'h7F800000, 32'hFF800000, 1, 32'h7FC00000, 1, 0);
      issue(3'd3, 32'h3F800000, 32'h00000000, 1, 32'h7F800000, 0, 1);
      issue(3'd2, 32'h7F800000, 32'h3F800000, 1, 32'h7F800000, 0, 0);
      @(negedge clk);
      valid_in = 1'b0;
      reset = 1'b1;
      sb_q.delete();
      #1;
      chk("rst_inflight_out", {out_valid, spec_hit, invalid, div_zero, spec_result}, 0);
      chk("rst_inflight_sticky", {sticky_inv, sticky_dz}, 0);
      chk("rst_inflight_cnt", inv_cnt, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ov_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      chk("no_out_after_reset", ov_seen, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
